// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the stopwatch controller.
// Optional lap function is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam int CLK_HZ_DEF    = 50_000_000;
  localparam int TICK_HZ_DEF   = 100;
  localparam int DB_CYCLES_DEF = 500_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, press-edge pulse.
// Accepted level flips after DB_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
      // any sample matching the accepted level restarts the window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        cnt <= '0;
        lvl <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons, IDLE/RUN/LAP/STOP, tick prescaler.
// Define STOPWATCH_LAP_EN to build the lap button and LAP state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int TICK_HZ   = TICK_HZ_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       ena,
  output logic       clear,
  output logic       oen,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_TOP = PW'(DIV - 1);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  logic ss_p;
  logic lap_p;
  logic clr_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_ss),
    .press (ss_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .press (clr_p)
  );

`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_lap),
    .press (lap_p)
  );
`else
  logic lap_unused;
  assign lap_unused = btn_lap;
  assign lap_p      = 1'b0;
`endif

  // same-cycle priority: clear, then start/stop, then lap
  logic c_p;
  logic s_p;
  logic l_p;
  assign c_p = clr_p;
  assign s_p = ss_p & ~clr_p;
  assign l_p = lap_p & ~clr_p & ~ss_p;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          ena_q;
  logic          ena_d;
  logic          clear_q;
  logic          clear_d;
  logic          oen_q;
  logic          oen_d;
  logic          running;

  assign running = (state_q == ST_RUN) || (state_q == ST_LAP);

  always_comb begin
    state_d = state_q;
    oen_d   = oen_q;
    clear_d = 1'b0;
    ena_d   = 1'b0;
    presc_d = presc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_p)      state_d = ST_RUN;
        else if (c_p) clear_d = 1'b1;
      end
      ST_RUN: begin
        if (s_p) begin
          state_d = ST_STOP;
        end else if (l_p) begin
          state_d = ST_LAP;
          oen_d   = 1'b1;
        end
      end
      ST_LAP: begin
        if (s_p) begin
          state_d = ST_STOP;
          oen_d   = 1'b0;
        end else if (l_p) begin
          state_d = ST_RUN;
          oen_d   = 1'b0;
        end
      end
      ST_STOP: begin
        if (s_p) begin
          state_d = ST_RUN;
        end else if (c_p) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (running) begin
      if (presc_q == PS_TOP) begin
        presc_d = '0;
        ena_d   = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // clear only occurs from IDLE/STOP, so it never meets a tick
    if (clear_d) begin
      presc_d = '0;
      ena_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      ena_q   <= 1'b0;
      clear_q <= 1'b0;
      oen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ena_q   <= ena_d;
      clear_q <= clear_d;
      oen_q   <= oen_d;
    end
  end

  assign ena   = ena_q;
  assign clear = clear_q;
  assign oen   = oen_q;
  assign state = state_q;

endmodule
